// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the framer state type.
// Also intended for the receive-side FCS checker.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
   localparam logic [31:0] ETH_CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] ETH_CRC32_INIT    = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_PAYLOAD,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } framer_state_e;

endpackage

// File: rtl/axis_eth_framer_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the Ethernet framer.
interface axis_eth_framer_if;

   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB-first), purely combinational.
module eth_crc32_byte
   import eth_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next
);

   always_comb begin
      crc_next = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         crc_next = crc_next[0] ? ((crc_next >> 1) ^ ETH_CRC32_POLY) : (crc_next >> 1);
      end
   end

endmodule

// File: rtl/axis_eth_framer.sv
// Wraps a raw Ethernet frame with preamble/SFD, minimum-length padding and FCS,
// then enforces the inter-frame gap before accepting the next frame.
module axis_eth_framer
   import eth_pkg::*;
#(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int ENABLE_PAD      = 1,
   parameter int IFG_BYTES       = 12
)
(
   input  logic              clock,
   input  logic              reset,
   axis_eth_framer_if.slave  saxis,
   axis_eth_framer_if.master maxis
);

   localparam int GAP_MAX = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
   localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
   localparam int CNT_W   = (MIN_FRAME_BYTES < 2) ? 1 : $clog2(MIN_FRAME_BYTES + 1);

   framer_state_e    state;
   logic [GAP_W-1:0] gap_count;
   logic [CNT_W-1:0] byte_count;
   logic [CNT_W-1:0] byte_count_inc;
   logic [1:0]       fcs_index;
   logic [31:0]      crc;
   logic [31:0]      crc_next;
   logic [31:0]      fcs_shifted;
   logic [7:0]       crc_byte;
   logic             advance;

   assign advance      = !maxis.tvalid || maxis.tready;
   assign saxis.tready = (state == ST_PAYLOAD) && advance;

   // Byte count only matters up to the minimum length, so it saturates there.
   assign byte_count_inc = (byte_count == CNT_W'(MIN_FRAME_BYTES)) ? byte_count
                                                                   : byte_count + CNT_W'(1);

   assign crc_byte    = (state == ST_PAYLOAD) ? saxis.tdata : 8'h00;
   assign fcs_shifted = ~crc >> {fcs_index, 3'b000};

   eth_crc32_byte u_crc (
      .crc      (crc),
      .data     (crc_byte),
      .crc_next (crc_next)
   );

   // Every state loads the output register only on advance, so a stalled sink freezes everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         maxis.tvalid <= 1'b0;
         maxis.tdata  <= 8'h00;
         maxis.tlast  <= 1'b0;
         gap_count    <= '0;
         byte_count   <= '0;
         fcs_index    <= 2'd0;
         crc          <= ETH_CRC32_INIT;
      end else if (advance) begin
         unique case (state)
            ST_IDLE: begin
               maxis.tvalid <= 1'b0;
               maxis.tlast  <= 1'b0;
               if (saxis.tvalid) begin
                  state      <= ST_PREAMBLE;
                  gap_count  <= '0;
                  byte_count <= '0;
                  fcs_index  <= 2'd0;
                  crc        <= ETH_CRC32_INIT;
               end
            end
            ST_PREAMBLE: begin
               maxis.tdata  <= ETH_PREAMBLE_BYTE;
               maxis.tvalid <= 1'b1;
               maxis.tlast  <= 1'b0;
               if (gap_count == GAP_W'(PREAMBLE_BYTES - 1)) begin
                  gap_count <= '0;
                  state     <= ST_SFD;
               end else begin
                  gap_count <= gap_count + GAP_W'(1);
               end
            end
            ST_SFD: begin
               maxis.tdata  <= ETH_SFD_BYTE;
               maxis.tvalid <= 1'b1;
               state        <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               // Upstream gaps pass straight through as output bubbles.
               if (saxis.tvalid) begin
                  maxis.tdata  <= saxis.tdata;
                  maxis.tvalid <= 1'b1;
                  crc          <= crc_next;
                  byte_count   <= byte_count_inc;
                  if (saxis.tlast) begin
                     state <= ((ENABLE_PAD != 0) && (byte_count_inc < CNT_W'(MIN_FRAME_BYTES)))
                              ? ST_PAD : ST_FCS;
                  end
               end else begin
                  maxis.tvalid <= 1'b0;
               end
            end
            ST_PAD: begin
               maxis.tdata  <= 8'h00;
               maxis.tvalid <= 1'b1;
               crc          <= crc_next;
               byte_count   <= byte_count_inc;
               if (byte_count_inc == CNT_W'(MIN_FRAME_BYTES)) begin
                  state <= ST_FCS;
               end
            end
            ST_FCS: begin
               maxis.tdata  <= fcs_shifted[7:0];
               maxis.tvalid <= 1'b1;
               maxis.tlast  <= (fcs_index == 2'd3);
               fcs_index    <= fcs_index + 2'd1;
               if (fcs_index == 2'd3) begin
                  state     <= ST_IFG;
                  gap_count <= '0;
               end
            end
            ST_IFG: begin
               // First advance here is the last FCS handshake; idle cycles are counted from it.
               maxis.tvalid <= 1'b0;
               maxis.tlast  <= 1'b0;
               if (gap_count == GAP_W'(IFG_BYTES - 1)) begin
                  gap_count <= '0;
                  crc       <= ETH_CRC32_INIT;
                  state     <= ST_IDLE;
               end else begin
                  gap_count <= gap_count + GAP_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_eth_framer.sv
// Randomised bench for axis_eth_framer: one unpadded and one padded instance,
// both compared against a queue-based frame model.
module tb_axis_eth_framer;

   localparam int IFG = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   axis_eth_framer_if s_np ();
   axis_eth_framer_if m_np ();
   axis_eth_framer_if s_pd ();
   axis_eth_framer_if m_pd ();

   logic [7:0] src_data   = 8'h00;
   logic       src_valid  = 1'b0;
   logic       src_last   = 1'b0;
   logic       sink_ready = 1'b1;
   logic       src_ready;
   int         target     = 0;
   bit         rand_ready = 0;
   bit         abort_drv  = 0;
   bit         drv_busy   = 0;
   int         cyc        = 0;

   int checks = 0;
   int passes = 0;

   assign s_np.tdata  = src_data;
   assign s_np.tlast  = src_last;
   assign s_np.tvalid = src_valid && (target == 0);
   assign s_pd.tdata  = src_data;
   assign s_pd.tlast  = src_last;
   assign s_pd.tvalid = src_valid && (target == 1);
   assign src_ready   = (target == 1) ? s_pd.tready : s_np.tready;
   assign m_np.tready = sink_ready;
   assign m_pd.tready = sink_ready;

   axis_eth_framer #(.ENABLE_PAD(0)) dut_np (
      .clock (clock),
      .reset (reset),
      .saxis (s_np),
      .maxis (m_np)
   );

   axis_eth_framer dut_pd (
      .clock (clock),
      .reset (reset),
      .saxis (s_pd),
      .maxis (m_pd)
   );

   logic [7:0] np_q[$];
   bit         np_lq[$];
   logic [7:0] pd_q[$];
   bit         pd_lq[$];
   int         pd_cq[$];
   bit         np_stall = 0;
   bit         pd_stall = 0;
   logic [8:0] np_prev  = '0;
   logic [8:0] pd_prev  = '0;

   logic [7:0] pay[$];
   logic [8:0] src_q[$];
   logic [7:0] exp_q[$];
   bit         exp_lq[$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Output monitors: capture handshaken bytes and verify stalled outputs hold still.
   initial forever begin
      @(negedge clock);
      if (reset) np_stall = 0;
      else begin
         if (np_stall)
            checkOutput("np_hold", {22'd0, m_np.tvalid, m_np.tlast, m_np.tdata}, {22'd0, 1'b1, np_prev});
         if (m_np.tvalid && m_np.tready) begin
            np_q.push_back(m_np.tdata);
            np_lq.push_back(m_np.tlast);
         end
         np_stall = m_np.tvalid && !m_np.tready;
         np_prev  = {m_np.tlast, m_np.tdata};
      end
   end

   initial forever begin
      @(negedge clock);
      if (reset) pd_stall = 0;
      else begin
         if (pd_stall)
            checkOutput("pd_hold", {22'd0, m_pd.tvalid, m_pd.tlast, m_pd.tdata}, {22'd0, 1'b1, pd_prev});
         if (m_pd.tvalid && m_pd.tready) begin
            pd_q.push_back(m_pd.tdata);
            pd_lq.push_back(m_pd.tlast);
            pd_cq.push_back(cyc);
         end
         pd_stall = m_pd.tvalid && !m_pd.tready;
         pd_prev  = {m_pd.tlast, m_pd.tdata};
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      sink_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
   end

   // Wire image of one frame: preamble, SFD, body padded to 60, FCS LSB first.
   task automatic buildExpected(input bit pad);
      logic [7:0]  body[$];
      logic [31:0] c;
      logic [31:0] fcs;
      bit          fb;
      body = pay;
      if (pad) while (body.size() < 60) body.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (body[i]) begin
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ body[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      fcs = ~c;
      for (int k = 0; k < 7; k++) begin exp_q.push_back(8'h55); exp_lq.push_back(0); end
      exp_q.push_back(8'hD5); exp_lq.push_back(0);
      foreach (body[i]) begin exp_q.push_back(body[i]); exp_lq.push_back(0); end
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(fcs[8*k +: 8]);
         exp_lq.push_back(k == 3);
      end
   endtask

   task automatic setCase1Expected();
      logic [7:0] fcs_lit[4];
      fcs_lit = '{8'h26, 8'h39, 8'hF4, 8'hCB};
      exp_q.delete(); exp_lq.delete();
      for (int k = 0; k < 7; k++) begin exp_q.push_back(8'h55); exp_lq.push_back(0); end
      exp_q.push_back(8'hD5); exp_lq.push_back(0);
      for (int k = 0; k < 9; k++) begin exp_q.push_back(8'h31 + 8'(k)); exp_lq.push_back(0); end
      for (int k = 0; k < 4; k++) begin exp_q.push_back(fcs_lit[k]); exp_lq.push_back(k == 3); end
   endtask

   task automatic addSource();
      foreach (pay[i]) src_q.push_back({(i == pay.size() - 1) ? 1'b1 : 1'b0, pay[i]});
   endtask

   task automatic startCase(input int tgt);
      target = tgt;
      np_q.delete(); np_lq.delete();
      pd_q.delete(); pd_lq.delete(); pd_cq.delete();
      src_q.delete(); exp_q.delete(); exp_lq.delete();
   endtask

   task automatic applyStimulus(input int bubble_pct);
      int guard;
      drv_busy = 1;
      foreach (src_q[i]) begin
         if (abort_drv) break;
         if (int'($urandom_range(99)) < bubble_pct) begin
            src_valid = 0;
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
         end
         src_data  = src_q[i][7:0];
         src_last  = src_q[i][8];
         src_valid = 1;
         guard     = 0;
         do begin
            @(negedge clock);
            guard++;
         end while (!src_ready && !abort_drv && guard < 5000);
         if (abort_drv) break;
         if (!src_ready) begin
            checkOutput("src_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge clock);
         #1;
      end
      src_valid = 0;
      src_last  = 0;
      drv_busy  = 0;
   endtask

   task automatic waitOutput(input int tgt, input int n);
      int guard = 0;
      while (((tgt == 0) ? np_q.size() : pd_q.size()) < n && guard < 20000) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 20000) checkOutput("out_timeout", 32'd0, 32'd1);
      repeat (IFG + 6) @(negedge clock);
   endtask

   task automatic compareFrame(input int tgt, input string tag);
      logic [7:0] d[$];
      bit         l[$];
      int         n;
      if (tgt == 0) begin d = np_q; l = np_lq; end
      else          begin d = pd_q; l = pd_lq; end
      checkOutput($sformatf("%s_len", tag), d.size(), exp_q.size());
      n = (d.size() < exp_q.size()) ? d.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, d[i]}, {24'd0, exp_q[i]});
         checkOutput($sformatf("%s_last%0d", tag, i), {31'd0, l[i]}, {31'd0, exp_lq[i]});
      end
   endtask

   task automatic runCase(input int bubble, input bit rnd, input string tag);
      rand_ready = rnd;
      applyStimulus(bubble);
      waitOutput(target, exp_q.size());
      rand_ready = 0;
      compareFrame(target, tag);
   endtask

   initial begin
      int split;
      int gap;
      int ones;
      int guard;

      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_np_tvalid", {31'd0, m_np.tvalid}, 32'd0);
      checkOutput("rst_np_tdata",  {24'd0, m_np.tdata},  32'd0);
      checkOutput("rst_np_tlast",  {31'd0, m_np.tlast},  32'd0);
      checkOutput("rst_np_tready", {31'd0, s_np.tready}, 32'd0);
      checkOutput("rst_pd_tvalid", {31'd0, m_pd.tvalid}, 32'd0);
      checkOutput("rst_pd_tdata",  {24'd0, m_pd.tdata},  32'd0);
      checkOutput("rst_pd_tready", {31'd0, s_pd.tready}, 32'd0);
      @(posedge clock);
      #1;
      reset = 0;
      repeat (2) @(posedge clock);
      #1;

      // "123456789" without padding.
      startCase(0);
      for (int k = 0; k < 9; k++) pay.push_back(8'h31 + 8'(k));
      pay.delete();
      for (int k = 0; k < 9; k++) pay.push_back(8'h31 + 8'(k));
      addSource();
      setCase1Expected();
      runCase(0, 0, "crc_check");

      // Single-byte frame padded to minimum, then again under backpressure.
      startCase(1);
      pay.delete(); pay.push_back(8'hAB);
      addSource(); buildExpected(1);
      runCase(0, 0, "one_byte");
      startCase(1);
      addSource(); buildExpected(1);
      runCase(0, 1, "one_byte_stall");

      // 64-byte frame, no padding needed.
      startCase(1);
      pay.delete();
      for (int k = 0; k < 64; k++) pay.push_back(8'(k));
      addSource(); buildExpected(1);
      runCase(0, 0, "inc64");

      // Random frames, random target, upstream bubbles and sink stalls.
      for (int r = 0; r < 6; r++) begin
         int tgt;
         int len;
         tgt = int'($urandom_range(1));
         len = int'($urandom_range(1, 90));
         startCase(tgt);
         pay.delete();
         for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
         addSource(); buildExpected(tgt == 1);
         runCase(int'($urandom_range(0, 30)), 1'($urandom_range(1)), $sformatf("rand%0d", r));
      end

      // Back-to-back frames: measure idle gap between them.
      startCase(1);
      pay.delete();
      for (int k = 0; k < 20; k++) pay.push_back(8'($urandom));
      addSource(); buildExpected(1);
      split = exp_q.size();
      pay.delete();
      for (int k = 0; k < 65; k++) pay.push_back(8'($urandom));
      addSource(); buildExpected(1);
      runCase(0, 0, "b2b");
      gap = (pd_cq.size() > split) ? (pd_cq[split] - pd_cq[split - 1] - 1) : 0;
      checkOutput("ifg_gap_ge12", {31'd0, (gap >= IFG) ? 1'b1 : 1'b0}, 32'd1);

      // Reset after 10 payload bytes, then the reference frame again.
      startCase(0);
      pay.delete();
      for (int k = 0; k < 20; k++) pay.push_back(8'($urandom));
      addSource();
      fork
         applyStimulus(0);
      join_none
      guard = 0;
      while (np_q.size() < 18 && guard < 2000) begin @(negedge clock); guard++; end
      if (guard >= 2000) checkOutput("abort_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
      reset     = 1;
      abort_drv = 1;
      src_valid = 0;
      @(posedge clock);
      @(negedge clock);
      checkOutput("abort_tvalid", {31'd0, m_np.tvalid}, 32'd0);
      checkOutput("abort_tlast",  {31'd0, m_np.tlast},  32'd0);
      ones = 0;
      foreach (np_lq[i]) ones += int'(np_lq[i]);
      checkOutput("abort_no_tlast", ones, 32'd0);
      guard = 0;
      while (drv_busy && guard < 100) begin @(negedge clock); guard++; end
      @(posedge clock);
      #1;
      reset     = 0;
      abort_drv = 0;
      repeat (2) @(posedge clock);
      #1;
      startCase(0);
      pay.delete();
      for (int k = 0; k < 9; k++) pay.push_back(8'h31 + 8'(k));
      addSource();
      setCase1Expected();
      runCase(0, 0, "after_reset");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
